fork_join_sync: RTL and testbench
=================================

Name: fork_join_sync

Overview:
- Synthesizable hardware fork/join synchroniser: one start launches up to N parallel timed "tasks" (channels), each a programmable countdown.
- Per-channel completion is reported, plus a join event selected by mode (ALL / ANY / NONE) and a final all-complete event (wait-fork equivalent).
- Supports abort (disable-fork equivalent).
- Sits between a sequencing controller and N downstream operations whose completion must be synchronised.

Parameters:
- N, 3, number of channels (1..32).
- DW, 8, delay width per channel in bits.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  launch request; sampled each rising edge.
- mode_i  input  2  join mode, latched at start: 0 = JOIN_ALL, 1 = JOIN_ANY, 2 = JOIN_NONE, 3 = reserved (treated as JOIN_ALL).
- ch_en_i  input  N  channel enable mask, latched at start.
- delay_i  input  N*DW  per-channel delay; channel i uses bits [i*DW +: DW]; latched at start.
- abort_i  input  1  kill all active channels.
- busy_o  output  1  high while any channel is active.
- ch_active_o  output  N  per-channel running flag.
- ch_done_o  output  N  per-channel one-cycle completion pulse.
- join_o  output  1  one-cycle join pulse.
- first_id_o  output  $clog2(N) (min 1)  index of the first channel to complete; held until next accepted start.
- all_done_o  output  1  one-cycle pulse when every launched channel has completed.
- done_cnt_o  output  $clog2(N+1)  count of channels completed in the current or last run.
- overrun_o  output  1  one-cycle pulse when start_i is rejected while busy.

Behaviour:
- Reset (async assert, sync release): all outputs 0, all counters 0, FSM IDLE.
- All outputs are registered.
- FSM states: IDLE, RUN.
- IDLE, start_i=1 at edge E0 with ch_en_i != 0:
  - Latch mode, mask and delays; load cnt[i] = delay_i[i] for enabled channels.
  - Set ch_active for enabled channels; clear done_cnt_o and first_id_o.
  - Go to RUN; busy_o high after E0.
- IDLE, start_i=1 with ch_en_i == 0: stay IDLE; join_o and all_done_o pulse after E1 (empty fork completes immediately).
- RUN, each edge, for each active channel i:
  - cnt==0: pulse ch_done_o[i] and clear ch_active[i].
  - otherwise: decrement cnt.
  - Result: a channel with delay d pulses ch_done_o after edge E(d+1), i.e. d=0 completes one cycle after start. Max d = 2^DW-1.
- done_cnt_o increments by the number of channels completing that cycle (several may complete at once).
- join_o, exactly one pulse per run:
  - JOIN_ALL: in the cycle of the last completion, coincident with all_done_o.
  - JOIN_ANY: in the cycle of the first completion. On ties, first_id_o = lowest completing index.
  - JOIN_NONE: after E1, regardless of the channel delays.
- first_id_o is updated in all modes, at the first-completion cycle.
- When the last active channel completes: pulse all_done_o, FSM returns to IDLE at the same edge, and busy_o drops in the same cycle all_done_o is high. A start in that cycle is accepted.
- start_i while in RUN: ignored; pulse overrun_o; latched state unchanged.
- abort_i in RUN (priority over completions in the same cycle):
  - Clear all ch_active and counters; go to IDLE.
  - No ch_done_o, join_o or all_done_o from that cycle on.
  - done_cnt_o holds its value.
  - A JOIN_NONE join pulse already issued stands.
- abort_i in IDLE: no effect. abort_i and start_i in the same IDLE cycle: abort wins, start is dropped, no overrun_o.
- Reset mid-run: immediate return to the reset state; no pulses.

Test Plan:
- N=3, delays {30,12,10}, mask 111, JOIN_ANY, start at E0 -> ch2 done and join_o at E11, first_id_o=2; ch1 done at E13; ch0 done and all_done_o at E31; done_cnt_o=3; busy_o low from E31.
- Same delays, JOIN_ALL -> single join_o coincident with all_done_o at E31; no earlier join_o.
- JOIN_NONE, delays {5,0,7} -> join_o and ch1 done at E1; all_done_o at E8; start asserted at E4 -> overrun_o at E4, run otherwise unaffected.
- Tie: delays {4,4,9}, JOIN_ANY -> ch0 and ch1 done together at E5, one join_o, first_id_o=0, done_cnt_o=2 after E5.
- Abort: delays {20,20,20}, abort_i at E6 -> busy_o low after E6, no done/join/all_done pulses; a new start at E7 is accepted normally.
- Mask 000 -> join_o and all_done_o at E1, busy_o never high. Async rst_n low at E3 of a running fork -> all outputs 0 immediately.

Source files
------------

// File: rtl/fork_join_sync.sv
// Fork/join synchroniser: one start launches up to N countdown channels and reports per-channel, join and all-done events.
// Outputs are registered; starts arriving while a run is in progress are dropped and flagged on overrun_o.
module fork_join_sync #(
  parameter int N  = 3,
  parameter int DW = 8,
  localparam int FW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [1:0]    mode_i,
  input  logic [N-1:0]  ch_en_i,
  input  logic [N*DW-1:0] delay_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic [N-1:0]  ch_active_o,
  output logic [N-1:0]  ch_done_o,
  output logic          join_o,
  output logic [FW-1:0] first_id_o,
  output logic          all_done_o,
  output logic [CW-1:0] done_cnt_o,
  output logic          overrun_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] M_ALL  = 2'd0;
  localparam logic [1:0] M_ANY  = 2'd1;
  localparam logic [1:0] M_NONE = 2'd2;

  state_t        r_state, w_state;
  logic [1:0]    r_mode, w_mode;
  logic [DW-1:0] r_cnt [N];
  logic [DW-1:0] w_cnt [N];
  logic [N-1:0]  r_active, w_active;
  logic [N-1:0]  r_done, w_done;
  logic          r_join, w_join;
  logic [FW-1:0] r_first_id, w_first_id;
  logic          r_all_done, w_all_done;
  logic [CW-1:0] r_done_cnt, w_done_cnt;
  logic          r_overrun, w_overrun;
  logic          r_first_edge, w_first_edge;
  logic          r_any_done, w_any_done;
  logic          r_empty_pend, w_empty_pend;

  logic [N-1:0]  w_fin;
  logic [CW-1:0] w_fin_cnt;
  logic [FW-1:0] w_lowest;

  always_comb begin
    w_state      = r_state;
    w_mode       = r_mode;
    w_cnt        = r_cnt;
    w_active     = r_active;
    w_done       = '0;
    w_join       = 1'b0;
    w_first_id   = r_first_id;
    w_all_done   = 1'b0;
    w_done_cnt   = r_done_cnt;
    w_overrun    = 1'b0;
    w_first_edge = 1'b0;
    w_any_done   = r_any_done;
    w_empty_pend = 1'b0;
    w_fin        = '0;
    w_fin_cnt    = '0;
    w_lowest     = '0;

    // An empty fork completes one cycle after its start.
    if (r_empty_pend) begin
      w_join     = 1'b1;
      w_all_done = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_done_cnt = '0;
          w_first_id = '0;
          if (ch_en_i != '0) begin
            w_state      = S_RUN;
            w_mode       = (mode_i == 2'd3) ? M_ALL : mode_i;
            w_active     = ch_en_i;
            w_first_edge = 1'b1;
            w_any_done   = 1'b0;
            for (int i = 0; i < N; i++) begin
              w_cnt[i] = ch_en_i[i] ? delay_i[i*DW +: DW] : '0;
            end
          end else begin
            w_empty_pend = 1'b1;
          end
        end
      end

      S_RUN: begin
        w_overrun = start_i;
        if (abort_i) begin
          w_state  = S_IDLE;
          w_active = '0;
          for (int i = 0; i < N; i++) begin
            w_cnt[i] = '0;
          end
        end else begin
          for (int i = 0; i < N; i++) begin
            if (r_active[i]) begin
              if (r_cnt[i] == '0) begin
                w_fin[i] = 1'b1;
              end else begin
                w_cnt[i] = r_cnt[i] - DW'(1);
              end
            end
            w_fin_cnt = w_fin_cnt + CW'(w_fin[i]);
          end
          for (int i = N - 1; i >= 0; i--) begin
            if (w_fin[i]) begin
              w_lowest = FW'(i);
            end
          end

          w_done     = w_fin;
          w_active   = r_active & ~w_fin;
          w_done_cnt = r_done_cnt + w_fin_cnt;

          // Ties on the first completion resolve to the lowest index.
          if ((w_fin != '0) && !r_any_done) begin
            w_any_done = 1'b1;
            w_first_id = w_lowest;
            if (r_mode == M_ANY) begin
              w_join = 1'b1;
            end
          end

          if (r_first_edge && (r_mode == M_NONE)) begin
            w_join = 1'b1;
          end

          if (w_active == '0) begin
            w_state    = S_IDLE;
            w_all_done = 1'b1;
            if (r_mode == M_ALL) begin
              w_join = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= M_ALL;
      r_active     <= '0;
      r_done       <= '0;
      r_join       <= 1'b0;
      r_first_id   <= '0;
      r_all_done   <= 1'b0;
      r_done_cnt   <= '0;
      r_overrun    <= 1'b0;
      r_first_edge <= 1'b0;
      r_any_done   <= 1'b0;
      r_empty_pend <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state      <= w_state;
      r_mode       <= w_mode;
      r_cnt        <= w_cnt;
      r_active     <= w_active;
      r_done       <= w_done;
      r_join       <= w_join;
      r_first_id   <= w_first_id;
      r_all_done   <= w_all_done;
      r_done_cnt   <= w_done_cnt;
      r_overrun    <= w_overrun;
      r_first_edge <= w_first_edge;
      r_any_done   <= w_any_done;
      r_empty_pend <= w_empty_pend;
    end
  end

  assign busy_o      = (r_state == S_RUN);
  assign ch_active_o = r_active;
  assign ch_done_o   = r_done;
  assign join_o      = r_join;
  assign first_id_o  = r_first_id;
  assign all_done_o  = r_all_done;
  assign done_cnt_o  = r_done_cnt;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_fork_join_sync.sv
// Directed bench for fork_join_sync: edge-indexed event capture after each start, checked with immediate assertions.
module tb_fork_join_sync;
  localparam int N  = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [N-1:0]  ch_en_i;
  logic [N*DW-1:0] delay_i;
  logic          abort_i;
  logic          busy_o;
  logic [N-1:0]  ch_active_o;
  logic [N-1:0]  ch_done_o;
  logic          join_o;
  logic [1:0]    first_id_o;
  logic          all_done_o;
  logic [1:0]    done_cnt_o;
  logic          overrun_o;

  always #5 clk = ~clk;

  fork_join_sync #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .ch_en_i(ch_en_i),
    .delay_i(delay_i), .abort_i(abort_i), .busy_o(busy_o), .ch_active_o(ch_active_o),
    .ch_done_o(ch_done_o), .join_o(join_o), .first_id_o(first_id_o), .all_done_o(all_done_o),
    .done_cnt_o(done_cnt_o), .overrun_o(overrun_o)
  );

  int checks = 0;
  int errors = 0;

  int e, join_n, join_at, fid_at_join, alld_n, alld_at, ovr_n, ovr_at, done_n, busy_fall, busy_seen;
  int done_at [N];
  int dcnt_hist [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_watch();
    e = 0; join_n = 0; join_at = -1; fid_at_join = -1; alld_n = 0; alld_at = -1;
    ovr_n = 0; ovr_at = -1; done_n = 0; busy_fall = -1; busy_seen = 0;
    for (int c = 0; c < N; c++) done_at[c] = -1;
    for (int k = 0; k < 64; k++) dcnt_hist[k] = -1;
  endtask

  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      e++;
      if (join_o) begin
        join_n++;
        if (join_at < 0) begin
          join_at = e;
          fid_at_join = int'(first_id_o);
        end
      end
      if (all_done_o) begin
        alld_n++;
        if (alld_at < 0) alld_at = e;
      end
      if (overrun_o) begin
        ovr_n++;
        if (ovr_at < 0) ovr_at = e;
      end
      for (int c = 0; c < N; c++) begin
        if (ch_done_o[c]) begin
          done_n++;
          if (done_at[c] < 0) done_at[c] = e;
        end
      end
      if (busy_o) busy_seen = 1;
      else if (busy_fall < 0) busy_fall = e;
      if (e < 64) dcnt_hist[e] = int'(done_cnt_o);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [N-1:0] en, input logic [N*DW-1:0] d);
    mode_i  = m;
    ch_en_i = en;
    delay_i = d;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    clear_watch();
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0; ch_en_i = '0; delay_i = '0;
    clear_watch();
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_active", ch_active_o, 0);
    chk("rst_pulses", {ch_done_o, join_o, all_done_o, overrun_o}, 0);
    chk("rst_cnt_id", {done_cnt_o, first_id_o}, 0);
    rst_n = 1'b1;
    tick();

    // JOIN_ANY, ch0=30 ch1=12 ch2=10
    launch(2'd1, 3'b111, {8'd10, 8'd12, 8'd30});
    chk("any_busy_e0", busy_o, 1);
    chk("any_active_e0", ch_active_o, 3'b111);
    watch(35);
    chk("any_join_at", join_at, 11);
    chk("any_join_n", join_n, 1);
    chk("any_fid_at_join", fid_at_join, 2);
    chk("any_done2", done_at[2], 11);
    chk("any_done1", done_at[1], 13);
    chk("any_done0", done_at[0], 31);
    chk("any_alld_at", alld_at, 31);
    chk("any_busy_fall", busy_fall, 31);
    chk("any_done_cnt", done_cnt_o, 3);
    chk("any_first_id", first_id_o, 2);

    // JOIN_ALL, same delays
    launch(2'd0, 3'b111, {8'd10, 8'd12, 8'd30});
    watch(33);
    chk("all_join_at", join_at, 31);
    chk("all_join_n", join_n, 1);
    chk("all_alld_at", alld_at, 31);
    chk("all_done_n", done_n, 3);

    // JOIN_NONE, ch0=5 ch1=0 ch2=7, rejected start at E4
    launch(2'd2, 3'b111, {8'd7, 8'd0, 8'd5});
    watch(3);
    start_i = 1'b1; mode_i = 2'd1; ch_en_i = 3'b001; delay_i = '1;
    watch(1);
    start_i = 1'b0;
    watch(6);
    chk("none_join_at", join_at, 1);
    chk("none_join_n", join_n, 1);
    chk("none_done1", done_at[1], 1);
    chk("none_done0", done_at[0], 6);
    chk("none_done2", done_at[2], 8);
    chk("none_alld_at", alld_at, 8);
    chk("none_ovr_at", ovr_at, 4);
    chk("none_ovr_n", ovr_n, 1);
    chk("none_first_id", first_id_o, 1);

    // Tie: ch0=4 ch1=4 ch2=9, JOIN_ANY
    launch(2'd1, 3'b111, {8'd9, 8'd4, 8'd4});
    watch(12);
    chk("tie_done0", done_at[0], 5);
    chk("tie_done1", done_at[1], 5);
    chk("tie_join_at", join_at, 5);
    chk("tie_join_n", join_n, 1);
    chk("tie_first_id", first_id_o, 0);
    chk("tie_cnt_e4", dcnt_hist[4], 0);
    chk("tie_cnt_e5", dcnt_hist[5], 2);
    chk("tie_alld_at", alld_at, 10);

    // Abort at E6 after ch1 completed at E3
    launch(2'd0, 3'b111, {8'd20, 8'd2, 8'd20});
    watch(5);
    abort_i = 1'b1;
    watch(1);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_active", ch_active_o, 0);
    chk("abort_done_cnt", done_cnt_o, 1);
    chk("abort_done_n", done_n, 1);
    chk("abort_join_alld", join_n + alld_n, 0);
    launch(2'd0, 3'b111, {8'd2, 8'd3, 8'd1});
    chk("abort_restart_busy", busy_o, 1);
    watch(6);
    chk("restart_done0", done_at[0], 2);
    chk("restart_done2", done_at[2], 3);
    chk("restart_join_at", join_at, 4);
    chk("restart_alld_at", alld_at, 4);
    chk("restart_done_cnt", done_cnt_o, 3);

    // Empty fork
    launch(2'd1, 3'b000, {8'd1, 8'd1, 8'd1});
    chk("empty_busy_e0", busy_o, 0);
    watch(3);
    chk("empty_join_at", join_at, 1);
    chk("empty_alld_at", alld_at, 1);
    chk("empty_join_n", join_n, 1);
    chk("empty_busy_seen", busy_seen, 0);

    // Async reset mid-run
    launch(2'd1, 3'b111, {8'd30, 8'd1, 8'd30});
    watch(3);
    chk("prerst_state", {busy_o, first_id_o, done_cnt_o}, {1'b1, 2'd1, 2'd1});
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_active", ch_active_o, 0);
    chk("midrst_cnt_id", {done_cnt_o, first_id_o}, 0);
    #20;
    rst_n = 1'b1;
    clear_watch();
    watch(4);
    chk("postrst_quiet", busy_seen + done_n + join_n + alld_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
